// File: rtl/ram_ctrl.sv
// Single-port RAM controller: clears the RAM after reset, then turns one
// valid/ready command at a time into registered RAM read/write requests.
module ram_ctrl #(
   parameter int AW       = 2,
   parameter int DW       = 2,
   parameter int READ_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          ram_read_rq,
   output logic          ram_write_rq,
   output logic [AW-1:0] ram_address,
   output logic [DW-1:0] ram_write_data,
   input  logic [DW-1:0] ram_read_data,
   output logic          init_done
);

   localparam logic [2:0] S_INIT  = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_WRITE = 3'd2;
   localparam logic [2:0] S_READ  = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   // The sweep counter has one extra bit so "all addresses written" is distinct from address 0.
   localparam logic [AW:0] SWEEP_END = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
   localparam logic [2:0]  LAT_LAST  = 3'(READ_LAT);

   logic [2:0]  state;
   logic [AW:0] init_cnt;
   logic [2:0]  lat_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= S_INIT;
         init_cnt       <= '0;
         lat_cnt        <= '0;
         init_done      <= 1'b0;
         cmd_ready      <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_data       <= '0;
         ram_read_rq    <= 1'b0;
         ram_write_rq   <= 1'b0;
         ram_address    <= '0;
         ram_write_data <= '0;
      end else begin
         case (state)
            S_INIT: begin
               if (init_cnt == SWEEP_END) begin
                  ram_write_rq <= 1'b0;
                  init_done    <= 1'b1;
                  cmd_ready    <= 1'b1;
                  state        <= S_IDLE;
               end else begin
                  ram_write_rq   <= 1'b1;
                  ram_address    <= init_cnt[AW-1:0];
                  ram_write_data <= '0;
                  init_cnt       <= init_cnt + CNT_ONE;
               end
            end
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready   <= 1'b0;
                  ram_address <= cmd_addr;
                  if (cmd_write) begin
                     ram_write_rq   <= 1'b1;
                     ram_write_data <= cmd_wdata;
                     state          <= S_WRITE;
                  end else begin
                     ram_read_rq <= 1'b1;
                     lat_cnt     <= 3'd1;
                     state       <= S_READ;
                  end
               end
            end
            S_WRITE: begin
               ram_write_rq <= 1'b0;
               cmd_ready    <= 1'b1;
               state        <= S_IDLE;
            end
            // Read data is sampled on the last cycle the request is held.
            S_READ: begin
               if (lat_cnt == LAT_LAST) begin
                  ram_read_rq <= 1'b0;
                  rsp_data    <= ram_read_data;
                  rsp_valid   <= 1'b1;
                  state       <= S_RESP;
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state        <= S_INIT;
               init_cnt     <= '0;
               init_done    <= 1'b0;
               cmd_ready    <= 1'b0;
               rsp_valid    <= 1'b0;
               ram_read_rq  <= 1'b0;
               ram_write_rq <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: two instances (READ_LAT 1 and 3), each with a
// small behavioural RAM, and a queue of expected read responses.
module tb_ram_ctrl;

   localparam int AW    = 2;
   localparam int DW    = 2;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic          cmd_valid_a = 1'b0, cmd_write_a = 1'b0, rsp_ready_a = 1'b0;
   logic [AW-1:0] cmd_addr_a = '0;
   logic [DW-1:0] cmd_wdata_a = '0;
   logic          cmd_ready_a, rsp_valid_a, ram_read_rq_a, ram_write_rq_a, init_done_a;
   logic [DW-1:0] rsp_data_a, ram_write_data_a, ram_read_data_a;
   logic [AW-1:0] ram_address_a;

   logic          cmd_valid_b = 1'b0, cmd_write_b = 1'b0, rsp_ready_b = 1'b0;
   logic [AW-1:0] cmd_addr_b = '0;
   logic [DW-1:0] cmd_wdata_b = '0;
   logic          cmd_ready_b, rsp_valid_b, ram_read_rq_b, ram_write_rq_b, init_done_b;
   logic [DW-1:0] rsp_data_b, ram_write_data_b, ram_read_data_b;
   logic [AW-1:0] ram_address_b;

   logic [DW-1:0] mem_a [DEPTH];
   logic [DW-1:0] mem_b [DEPTH];
   logic [DW-1:0] mdl_a [DEPTH];
   logic [DW-1:0] mdl_b [DEPTH];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] exp_v;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_ctrl #(.AW(AW), .DW(DW), .READ_LAT(1)) dut_a (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_write(cmd_write_a),
      .cmd_addr(cmd_addr_a), .cmd_wdata(cmd_wdata_a),
      .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_data(rsp_data_a),
      .ram_read_rq(ram_read_rq_a), .ram_write_rq(ram_write_rq_a),
      .ram_address(ram_address_a), .ram_write_data(ram_write_data_a),
      .ram_read_data(ram_read_data_a), .init_done(init_done_a)
   );

   ram_ctrl #(.AW(AW), .DW(DW), .READ_LAT(3)) dut_b (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write_b),
      .cmd_addr(cmd_addr_b), .cmd_wdata(cmd_wdata_b),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b),
      .ram_read_rq(ram_read_rq_b), .ram_write_rq(ram_write_rq_b),
      .ram_address(ram_address_b), .ram_write_data(ram_write_data_b),
      .ram_read_data(ram_read_data_b), .init_done(init_done_b)
   );

   // Behavioural RAMs: synchronous write, combinational read while requested.
   always @(posedge clk) begin
      if (ram_write_rq_a) mem_a[ram_address_a] <= ram_write_data_a;
      if (ram_write_rq_b) mem_b[ram_address_b] <= ram_write_data_b;
   end
   assign ram_read_data_a = ram_read_rq_a ? mem_a[ram_address_a] : '0;
   assign ram_read_data_b = ram_read_rq_b ? mem_b[ram_address_b] : '0;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check_output("rq_exclusive_a", 32'(ram_read_rq_a & ram_write_rq_a), 0);
      check_output("rq_exclusive_b", 32'(ram_read_rq_b & ram_write_rq_b), 0);
   endtask

   task automatic clear_models();
      for (int i = 0; i < DEPTH; i++) begin
         mdl_a[i] = '0;
         mdl_b[i] = '0;
      end
   endtask

   task automatic write_a(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      check_output("wr_cmd_ready", 32'(cmd_ready_a), 1);
      cmd_valid_a = 1'b1; cmd_write_a = 1'b1; cmd_addr_a = addr; cmd_wdata_a = data;
      tick();
      cmd_valid_a = 1'b0;
      mdl_a[addr] = data;
      check_output("wr_rq", 32'(ram_write_rq_a), 1);
      check_output("wr_addr", 32'(ram_address_a), 32'(addr));
      check_output("wr_data", 32'(ram_write_data_a), 32'(data));
      check_output("wr_busy", 32'(cmd_ready_a), 0);
      tick();
      check_output("wr_rq_end", 32'(ram_write_rq_a), 0);
      check_output("wr_no_rsp", 32'(rsp_valid_a), 0);
      check_output("wr_ready_again", 32'(cmd_ready_a), 1);
   endtask

   task automatic read_a(input logic [AW-1:0] addr, input int hold);
      cmd_valid_a = 1'b1; cmd_write_a = 1'b0; cmd_addr_a = addr;
      rsp_ready_a = (hold == 0);
      exp_q.push_back(mdl_a[addr]);
      tick();
      cmd_valid_a = 1'b0;
      check_output("rd_rq", 32'(ram_read_rq_a), 1);
      check_output("rd_addr", 32'(ram_address_a), 32'(addr));
      check_output("rd_no_rsp_yet", 32'(rsp_valid_a), 0);
      tick();
      check_output("rd_rq_end", 32'(ram_read_rq_a), 0);
      check_output("rd_rsp_valid", 32'(rsp_valid_a), 1);
      for (int h = 0; h < hold; h++) begin
         check_output("rd_hold_valid", 32'(rsp_valid_a), 1);
         check_output("rd_hold_data", 32'(rsp_data_a), 32'(exp_q[0]));
         check_output("rd_hold_busy", 32'(cmd_ready_a), 0);
         tick();
      end
      rsp_ready_a = 1'b1;
      check_output("rd_valid_at_pop", 32'(rsp_valid_a), 1);
      exp_v = exp_q.pop_front();
      check_output("rd_data", 32'(rsp_data_a), 32'(exp_v));
      tick();
      check_output("rd_rsp_done", 32'(rsp_valid_a), 0);
      check_output("rd_idle_ready", 32'(cmd_ready_a), 1);
   endtask

   initial begin
      clear_models();
      // A write held pending through reset and INIT must wait for IDLE.
      cmd_valid_a = 1'b1; cmd_write_a = 1'b1; cmd_addr_a = 2'd1; cmd_wdata_a = 2'd2;
      #2;
      check_output("rst_cmd_ready", 32'(cmd_ready_a), 0);
      check_output("rst_init_done", 32'(init_done_a), 0);
      check_output("rst_rsp_valid", 32'(rsp_valid_a), 0);
      check_output("rst_rsp_data", 32'(rsp_data_a), 0);
      check_output("rst_wr_rq", 32'(ram_write_rq_a), 0);
      check_output("rst_rd_rq", 32'(ram_read_rq_a), 0);
      check_output("rst_addr", 32'(ram_address_a), 0);
      check_output("rst_wdata", 32'(ram_write_data_a), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < DEPTH; i++) begin
         tick();
         check_output("init_wr_rq_a", 32'(ram_write_rq_a), 1);
         check_output("init_addr_a", 32'(ram_address_a), i);
         check_output("init_data_a", 32'(ram_write_data_a), 0);
         check_output("init_busy_a", 32'(cmd_ready_a), 0);
         check_output("init_done_low_a", 32'(init_done_a), 0);
         check_output("init_wr_rq_b", 32'(ram_write_rq_b), 1);
         check_output("init_addr_b", 32'(ram_address_b), i);
      end
      tick();
      check_output("init_done_a", 32'(init_done_a), 1);
      check_output("init_ready_a", 32'(cmd_ready_a), 1);
      check_output("init_wr_end_a", 32'(ram_write_rq_a), 0);
      check_output("init_done_b", 32'(init_done_b), 1);
      check_output("init_ready_b", 32'(cmd_ready_b), 1);

      tick();
      cmd_valid_a = 1'b0;
      mdl_a[1] = 2'd2;
      check_output("held_cmd_wr_rq", 32'(ram_write_rq_a), 1);
      check_output("held_cmd_addr", 32'(ram_address_a), 1);
      check_output("held_cmd_data", 32'(ram_write_data_a), 2);
      tick();
      check_output("held_cmd_wr_end", 32'(ram_write_rq_a), 0);
      check_output("addr_holds", 32'(ram_address_a), 1);
      check_output("wdata_holds", 32'(ram_write_data_a), 2);

      write_a(2'd2, 2'd3);
      read_a(2'd2, 0);
      read_a(2'd1, 0);
      read_a(2'd0, 0);
      write_a(2'd3, 2'd1);
      read_a(2'd3, 5);
      write_a(2'd0, 2'd2);
      read_a(2'd0, 0);

      // Long-latency instance: write then read address 1.
      cmd_valid_b = 1'b1; cmd_write_b = 1'b1; cmd_addr_b = 2'd1; cmd_wdata_b = 2'd3;
      tick();
      cmd_valid_b = 1'b0;
      mdl_b[1] = 2'd3;
      check_output("b_wr_rq", 32'(ram_write_rq_b), 1);
      tick();
      check_output("b_wr_done", 32'(cmd_ready_b), 1);
      cmd_valid_b = 1'b1; cmd_write_b = 1'b0; cmd_addr_b = 2'd1; rsp_ready_b = 1'b1;
      exp_q.push_back(mdl_b[1]);
      tick();
      cmd_valid_b = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         check_output("b_rd_rq", 32'(ram_read_rq_b), 1);
         check_output("b_rd_addr", 32'(ram_address_b), 1);
         check_output("b_rd_no_rsp", 32'(rsp_valid_b), 0);
         tick();
      end
      check_output("b_rd_rq_end", 32'(ram_read_rq_b), 0);
      check_output("b_rsp_valid", 32'(rsp_valid_b), 1);
      exp_v = exp_q.pop_front();
      check_output("b_rsp_data", 32'(rsp_data_b), 32'(exp_v));
      tick();
      check_output("b_rsp_done", 32'(rsp_valid_b), 0);
      check_output("b_idle_ready", 32'(cmd_ready_b), 1);

      // Abort a read in flight with an asynchronous reset pulse.
      cmd_valid_b = 1'b1; cmd_write_b = 1'b0; cmd_addr_b = 2'd1;
      tick();
      cmd_valid_b = 1'b0;
      tick();
      check_output("abort_rd_active", 32'(ram_read_rq_b), 1);
      rst = 1'b0;
      #1;
      check_output("abort_rd_rq", 32'(ram_read_rq_b), 0);
      check_output("abort_rsp_valid", 32'(rsp_valid_b), 0);
      check_output("abort_rsp_data", 32'(rsp_data_b), 0);
      check_output("abort_addr", 32'(ram_address_b), 0);
      check_output("abort_init_done", 32'(init_done_b), 0);
      check_output("abort_cmd_ready", 32'(cmd_ready_b), 0);
      check_output("abort_a_init_done", 32'(init_done_a), 0);
      check_output("abort_a_wdata", 32'(ram_write_data_a), 0);
      clear_models();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         check_output("reinit_wr_rq", 32'(ram_write_rq_b), 1);
         check_output("reinit_addr", 32'(ram_address_b), i);
         check_output("reinit_no_rsp", 32'(rsp_valid_b), 0);
         check_output("reinit_no_rd", 32'(ram_read_rq_b), 0);
      end
      tick();
      check_output("reinit_done", 32'(init_done_b), 1);
      check_output("reinit_no_rsp_end", 32'(rsp_valid_b), 0);
      check_output("reinit_queue_empty", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameter AW, default 2, RAM address width in bits.
REQ-002 Parameter DW, default 2, RAM data width in bits.
REQ-003 Parameter READ_LAT, default 1, cycles the RAM read request is held; legal range 1..4.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  controller accepts a command this cycle.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  AW  command address.
REQ-010 cmd_wdata  input  DW  write data.
REQ-011 rsp_valid  output  1  read data available.
REQ-012 rsp_ready  input  1  consumer takes read data.
REQ-013 rsp_data  output  DW  read data.
REQ-014 ram_read_rq  output  1  RAM read request.
REQ-015 ram_write_rq  output  1  RAM write request.
REQ-016 ram_address  output  AW  RAM address.
REQ-017 ram_write_data  output  DW  RAM write data.
REQ-018 ram_read_data  input  DW  RAM read data, combinational from RAM while ram_read_rq=1.
REQ-019 init_done  output  1  high once the post-reset clear sweep has completed.

Function
REQ-020 All outputs SHALL be driven from registers; no combinational path from any input to any output.
REQ-021 FSM states SHALL be INIT, IDLE, WRITE, READ, RESP.
REQ-022 INIT: ram_write_rq=1, ram_write_data=0, ram_address=init counter; counter increments 0 to 2^AW-1, one address per cycle; after the last address, go to IDLE and set init_done=1. Sweep takes exactly 2^AW cycles.
REQ-023 cmd_ready SHALL be 1 only in IDLE; cmd_valid outside IDLE is ignored (not captured, not lost-acknowledged).
REQ-024 Handshake: command is accepted in the cycle cmd_valid=1 and cmd_ready=1; cmd_addr/cmd_write/cmd_wdata are captured that edge.
REQ-025 Write accepted at cycle N: ram_write_rq=1 with captured address/data in cycle N+1 only, then IDLE; cmd_ready=1 again in N+2; no response generated.
REQ-026 Read accepted at cycle N: ram_read_rq=1 with captured address in cycles N+1..N+READ_LAT; ram_read_data captured at the end of cycle N+READ_LAT; rsp_valid=1 from cycle N+READ_LAT+1.
REQ-027 RESP: rsp_valid and rsp_data SHALL hold stable until the cycle rsp_valid=1 and rsp_ready=1; the next cycle is IDLE with rsp_valid=0.
REQ-028 ram_read_rq and ram_write_rq SHALL never be 1 in the same cycle; both SHALL be 0 in IDLE and RESP.
REQ-029 ram_address and ram_write_data SHALL hold their last value when no request is active.
REQ-030 Address values wrap naturally at AW bits; no out-of-range checking.
REQ-031 Sustained throughput: one write per 2 cycles; one read per READ_LAT+2 cycles with rsp_ready held high.

Reset
REQ-032 rst=0 SHALL immediately force: state INIT, init counter 0, init_done=0, cmd_ready=0, rsp_valid=0, rsp_data=0, ram_read_rq=0, ram_write_rq=0, ram_address=0, ram_write_data=0.
REQ-033 Reset mid-operation SHALL abort any command or pending response without completion; after release the full INIT sweep repeats.
REQ-034 First edge after rst release SHALL begin the INIT sweep at address 0.

Verification
REQ-035 Reset release, AW=2 -> ram_write_rq=1 with addresses 0,1,2,3 and data 0 on four consecutive cycles; init_done=1 and cmd_ready=1 on the fifth.
REQ-036 Write addr 2 data 3, then read addr 2 (READ_LAT=1, rsp_ready=1) -> ram_write_rq one cycle at address 2; ram_read_rq one cycle; rsp_valid one cycle with rsp_data=3.
REQ-037 Read with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable for all 5, cmd_ready=0 throughout, IDLE one cycle after rsp_ready rises.
REQ-038 READ_LAT=3, read addr 1 accepted cycle N -> ram_read_rq=1 in N+1..N+3, rsp_valid=1 in N+4; rq lines never simultaneously high (checked every cycle).
REQ-039 cmd_valid=1 held during INIT -> no capture until IDLE; rst pulsed low during READ -> outputs cleared asynchronously, no rsp_valid, INIT restarts at address 0.
